// File: rtl/clm_framework_gen_pkg.sv
// Shared types and constants for the masked-AES host framework.
package clm_fw_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Every random word sits in a 16-bit slot of the host bus.
  localparam int SLOT_W = 16;

  // Feedback taps of x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  // Top bit of random slot i; slot 0 starts just below the selector slot.
  function automatic int slot_hi(input int i, input int din_w);
    return din_w - 1 - SLOT_W - SLOT_W * i;
  endfunction

endpackage

// File: rtl/clm_framework_gen_if.sv
// Host bus and core handshake bundle of the framework.
interface clm_framework_gen_if #(
  parameter int D     = 8,
  parameter int NR    = 23,
  parameter int P_W   = 5,
  parameter int DIN_W = 512
);
  logic                EN;
  logic [127:0]        Kin;
  logic                Krdy;
  logic [DIN_W-1:0]    Din;
  logic                Drdy;
  logic [127:0]        Dout;
  logic                Kvld;
  logic                Dvld;
  logic                BSY;
  logic [1:0]          ERR;
  logic                core_go;
  logic [127:0]        core_pt;
  logic [127:0]        core_key;
  logic [NR*D-1:0]     core_rand;
  logic [P_W-1:0]      core_p;
  logic                core_done;
  logic [127:0]        core_ct;

  // Framework side.
  modport slave (
    input  EN, Kin, Krdy, Din, Drdy, core_done, core_ct,
    output Dout, Kvld, Dvld, BSY, ERR, core_go, core_pt, core_key, core_rand, core_p
  );

  // Host and core side.
  modport master (
    output EN, Kin, Krdy, Din, Drdy, core_done, core_ct,
    input  Dout, Kvld, Dvld, BSY, ERR, core_go, core_pt, core_key, core_rand, core_p
  );
endinterface

// File: rtl/clm_framework_gen_lfsr.sv
// 32-bit Fibonacci LFSR advancing D steps per enabled step.
module clm_fw_lfsr
  import clm_fw_pkg::*;
#(
  parameter int D = 8
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [31:0]   seed,
  input  logic          step,
  output logic [D-1:0]  rnd
);

  logic [31:0] lfsr_r;
  logic [31:0] lfsr_next_s;

  // Unrolled D single-bit shifts from the current state.
  always_comb begin
    lfsr_next_s = lfsr_r;
    for (int s = 0; s < D; s++) begin
      lfsr_next_s = {lfsr_next_s[30:0], ^(lfsr_next_s & LFSR_TAPS)};
    end
  end

  // Bits handed out this cycle are the low bits of the advanced state.
  assign rnd = lfsr_next_s[D-1:0];

  // State register: seed load (zero seed would lock up), else step.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_INIT;
    end else if (en) begin
      if (load) begin
        lfsr_r <= (seed == 32'h0000_0000) ? LFSR_INIT : seed;
      end else if (step) begin
        lfsr_r <= lfsr_next_s;
      end
    end
  end

endmodule

// File: rtl/clm_framework_gen.sv
// Host-side framework: loads key/data from the host bus, runs a start/done
// masked-AES core, returns the ciphertext and reports timeout/overrun.
module clm_framework_gen
  import clm_fw_pkg::*;
#(
  parameter int D         = 8,
  parameter int NR        = 23,
  parameter int P_W       = 5,
  parameter int DIN_W     = 512,
  parameter int RAND_MODE = 0,
  parameter int TIMEOUT   = 1024
) (
  input logic CLK,
  input logic rst,
  clm_framework_gen_if.slave bus
);

  localparam int RW    = NR * D;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              done_s;
  logic              tmo_s;
  logic              accept_s;
  logic              key_ld_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [127:0]      key_r;
  logic [127:0]      pt_r;
  logic [P_W-1:0]    p_r;
  logic [RW-1:0]     rand_r;
  logic [RW-1:0]     rand_din_s;
  logic [D-1:0]      rnd_s;
  logic [127:0]      dout_r;
  logic              dvld_r;
  logic              kvld_r;
  logic [1:0]        err_r;
  logic              unused_din_s;

  // Slot padding bits and bus bits between fields carry no information.
  assign unused_din_s = ^bus.Din;

  assign accept_s = (state_r == ST_IDLE) && bus.Drdy;
  assign key_ld_s = (state_r == ST_IDLE) && bus.Krdy;

  // Gather word i (top D bits of slot i) with word 0 in the MS position.
  for (genvar i = 0; i < NR; i++) begin : g_words
    assign rand_din_s[RW-1-D*i -: D] = bus.Din[slot_hi(i, DIN_W) -: D];
  end

  if (RAND_MODE == 1) begin : g_lfsr
    clm_fw_lfsr #(.D(D)) u_lfsr (
      .CLK  (CLK),
      .rst  (rst),
      .en   (bus.EN),
      .load (accept_s),
      .seed (bus.Din[slot_hi(0, DIN_W) -: 32]),
      .step (state_r == ST_RUN),
      .rnd  (rnd_s)
    );
  end else begin : g_static
    assign rnd_s = '0;
  end

  // Next state: done has priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Drdy) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.core_done) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; frozen while EN is low.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (bus.EN) begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: key/data latching, run counter, result capture and flags.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      key_r  <= '0;
      pt_r   <= '0;
      p_r    <= '0;
      rand_r <= '0;
      dout_r <= '0;
      dvld_r <= 1'b0;
      kvld_r <= 1'b0;
      err_r  <= 2'b00;
    end else if (bus.EN) begin
      kvld_r <= key_ld_s;
      dvld_r <= done_s;
      if (key_ld_s) begin
        key_r <= bus.Kin;
      end
      if (accept_s) begin
        pt_r   <= bus.Din[127:0];
        p_r    <= bus.Din[DIN_W-1 -: P_W];
        rand_r <= rand_din_s;
        err_r  <= 2'b00;
        cnt_r  <= '0;
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + 1'b1;
        if (RAND_MODE == 1) begin
          rand_r <= {rand_r[RW-D-1:0], rnd_s};
        end
        if (done_s) begin
          dout_r <= bus.core_ct;
        end
        if (tmo_s) begin
          err_r[0] <= 1'b1;
        end
        if (bus.Drdy) begin
          err_r[1] <= 1'b1;
        end
      end
    end
  end

  assign bus.Dout      = dout_r;
  assign bus.Kvld      = kvld_r;
  assign bus.Dvld      = dvld_r;
  assign bus.BSY       = (state_r == ST_RUN);
  assign bus.core_go   = (state_r == ST_RUN);
  assign bus.ERR       = err_r;
  assign bus.core_pt   = pt_r;
  assign bus.core_key  = key_r;
  assign bus.core_rand = rand_r;
  assign bus.core_p    = p_r;

endmodule

// File: tb/tb_clm_framework_gen.sv
// Bench: two framework instances (static and LFSR randomness) driven with
// the same directed stimulus and checked every cycle against a word-level model.
module tb_clm_framework_gen;

  localparam int D     = 8;
  localparam int NR    = 23;
  localparam int P_W   = 5;
  localparam int DIN_W = 512;
  localparam int TMO   = 16;
  localparam int RW    = NR * D;

  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic CLK = 1'b0;
  logic rst = 1'b0;
  always #5 CLK = ~CLK;

  logic              en, krdy, drdy, done;
  logic [127:0]      kin, ct;
  logic [DIN_W-1:0]  din;

  clm_framework_gen_if #(.D(D), .NR(NR), .P_W(P_W), .DIN_W(DIN_W)) bus0 ();
  clm_framework_gen_if #(.D(D), .NR(NR), .P_W(P_W), .DIN_W(DIN_W)) bus1 ();

  assign bus0.EN = en;   assign bus1.EN = en;
  assign bus0.Kin = kin; assign bus1.Kin = kin;
  assign bus0.Krdy = krdy; assign bus1.Krdy = krdy;
  assign bus0.Din = din; assign bus1.Din = din;
  assign bus0.Drdy = drdy; assign bus1.Drdy = drdy;
  assign bus0.core_done = done; assign bus1.core_done = done;
  assign bus0.core_ct = ct; assign bus1.core_ct = ct;

  clm_framework_gen #(.D(D), .NR(NR), .P_W(P_W), .DIN_W(DIN_W), .RAND_MODE(0), .TIMEOUT(TMO))
    dut0 (.CLK(CLK), .rst(rst), .bus(bus0));
  clm_framework_gen #(.D(D), .NR(NR), .P_W(P_W), .DIN_W(DIN_W), .RAND_MODE(1), .TIMEOUT(TMO))
    dut1 (.CLK(CLK), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Random words as a list, word 0 first (MS on the bus).
  typedef logic [0:NR-1][D-1:0] words_t;

  logic          m_run  [2];
  int            m_cnt  [2];
  logic [127:0]  m_key  [2];
  logic [127:0]  m_pt   [2];
  logic [127:0]  m_dout [2];
  logic [P_W-1:0] m_p   [2];
  words_t        m_rw   [2];
  logic          m_dvld [2];
  logic          m_kvld [2];
  logic [1:0]    m_err  [2];
  logic [31:0]   m_lfsr [2];

  function automatic words_t din_words(input logic [DIN_W-1:0] d);
    words_t w;
    for (int i = 0; i < NR; i++) w[i] = d[DIN_W-17-16*i -: D];
    return w;
  endfunction

  // Polynomial x^32+x^22+x^2+x+1 as a bit-serial Fibonacci register, D shifts.
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < D; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  function automatic logic [D-1:0] lfsr_word(input logic [31:0] s);
    logic [31:0] r;
    r = lfsr_adv(s);
    return r[D-1:0];
  endfunction

  // Model update: same inputs, rules applied per instance.
  always @(posedge CLK or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] <= 1'b0; m_cnt[k] <= 0; m_key[k] <= '0; m_pt[k] <= '0;
        m_dout[k] <= '0; m_p[k] <= '0; m_rw[k] <= '0; m_dvld[k] <= 1'b0;
        m_kvld[k] <= 1'b0; m_err[k] <= 2'b00; m_lfsr[k] <= 32'h1;
      end else if (en) begin
        m_kvld[k] <= krdy && !m_run[k];
        m_dvld[k] <= 1'b0;
        if (!m_run[k]) begin
          if (krdy) m_key[k] <= kin;
          if (drdy) begin
            m_run[k] <= 1'b1;
            m_cnt[k] <= 0;
            m_err[k] <= 2'b00;
            m_pt[k]  <= din[127:0];
            m_p[k]   <= din[DIN_W-1 -: P_W];
            m_rw[k]  <= din_words(din);
            if (k == 1) m_lfsr[k] <= (din[DIN_W-17 -: 32] == 32'h0) ? 32'h1 : din[DIN_W-17 -: 32];
          end
        end else begin
          m_cnt[k] <= m_cnt[k] + 1;
          if (drdy) m_err[k][1] <= 1'b1;
          if (k == 1) begin
            m_lfsr[k] <= lfsr_adv(m_lfsr[k]);
            m_rw[k]   <= {m_rw[k][1:NR-1], lfsr_word(m_lfsr[k])};
          end
          if (done) begin
            m_dout[k] <= ct;
            m_dvld[k] <= 1'b1;
            m_run[k]  <= 1'b0;
          end else if (m_cnt[k] == TMO - 1) begin
            m_err[k][0] <= 1'b1;
            m_run[k]    <= 1'b0;
          end
        end
      end
    end
  end

  task automatic cmp_dut(input int k, input logic [127:0] dout, input logic kvld, input logic dvld,
                         input logic bsy, input logic go, input logic [1:0] err,
                         input logic [127:0] pt, input logic [127:0] key,
                         input logic [RW-1:0] rnd, input logic [P_W-1:0] p);
    chk($sformatf("d%0d.Dout", k), 256'(dout), 256'(m_dout[k]));
    chk($sformatf("d%0d.Kvld", k), 256'(kvld), 256'(m_kvld[k]));
    chk($sformatf("d%0d.Dvld", k), 256'(dvld), 256'(m_dvld[k]));
    chk($sformatf("d%0d.BSY", k), 256'(bsy), 256'(m_run[k]));
    chk($sformatf("d%0d.core_go", k), 256'(go), 256'(m_run[k]));
    chk($sformatf("d%0d.ERR", k), 256'(err), 256'(m_err[k]));
    chk($sformatf("d%0d.core_pt", k), 256'(pt), 256'(m_pt[k]));
    chk($sformatf("d%0d.core_key", k), 256'(key), 256'(m_key[k]));
    chk($sformatf("d%0d.core_rand", k), 256'(rnd), 256'(m_rw[k]));
    chk($sformatf("d%0d.core_p", k), 256'(p), 256'(m_p[k]));
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge CLK) begin
    cmp_dut(0, bus0.Dout, bus0.Kvld, bus0.Dvld, bus0.BSY, bus0.core_go, bus0.ERR,
            bus0.core_pt, bus0.core_key, bus0.core_rand, bus0.core_p);
    cmp_dut(1, bus1.Dout, bus1.Kvld, bus1.Dvld, bus1.BSY, bus1.core_go, bus1.ERR,
            bus1.core_pt, bus1.core_key, bus1.core_rand, bus1.core_p);
  end

  // Free-running event counters on instance 0.
  int bsy_cnt = 0, dvld_cnt = 0, kvld_cnt = 0;
  always @(negedge CLK) begin
    if (bus0.BSY)  bsy_cnt  <= bsy_cnt + 1;
    if (bus0.Dvld) dvld_cnt <= dvld_cnt + 1;
    if (bus0.Kvld) kvld_cnt <= kvld_cnt + 1;
  end

  // ---------------- stimulus ----------------
  function automatic logic [DIN_W-1:0] mk_din(input logic [P_W-1:0] p, input logic [D-1:0] w,
                                              input logic [127:0] pt, input bit vary, input bit zero01);
    logic [DIN_W-1:0] d;
    d = '0;
    d[DIN_W-1 -: P_W] = p;
    d[DIN_W-1-P_W -: 16-P_W] = '1;
    for (int i = 0; i < NR; i++) begin
      if (!(zero01 && i < 2)) begin
        d[DIN_W-17-16*i -: D] = vary ? (w + D'(i)) : w;
        d[DIN_W-17-16*i-D -: 16-D] = '1;
      end
    end
    d[127:0] = pt;
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  int b0, v0, k0;

  initial begin
    en = 1'b1; krdy = 1'b0; drdy = 1'b0; done = 1'b0;
    kin = '0; ct = '0; din = '0;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset.Dout", 256'(bus0.Dout), 256'(0));
    chk("reset.BSY", 256'(bus0.BSY), 256'(0));
    chk("reset.ERR", 256'(bus1.ERR), 256'(0));
    tick(1);

    // Test 1: FIPS-197 load and run, done presented in the 11th RUN cycle.
    b0 = bsy_cnt; v0 = dvld_cnt; k0 = kvld_cnt;
    kin = AES_KEY; krdy = 1'b1;
    tick(1);
    krdy = 1'b0;
    chk("t1.Kvld", 256'(bus0.Kvld), 256'(1));
    chk("t1.key", 256'(bus0.core_key), 256'(AES_KEY));
    din = mk_din(5'h13, 8'hA5, AES_PT, 1'b0, 1'b0); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    chk("t1.go", 256'(bus0.core_go), 256'(1));
    chk("t1.pt", 256'(bus0.core_pt), 256'(AES_PT));
    chk("t1.rand0", 256'(bus0.core_rand[RW-1 -: D]), 256'(8'hA5));
    chk("t1.p", 256'(bus0.core_p), 256'(5'h13));
    tick(10);
    done = 1'b1; ct = AES_CT;
    tick(1);
    done = 1'b0;
    chk("t1.Dvld", 256'(bus0.Dvld), 256'(1));
    chk("t1.Dout", 256'(bus0.Dout), 256'(AES_CT));
    tick(2);
    chk("t1.bsy_cycles", 256'(bsy_cnt - b0), 256'(11));
    chk("t1.dvld_pulses", 256'(dvld_cnt - v0), 256'(1));
    chk("t1.kvld_pulses", 256'(kvld_cnt - k0), 256'(1));

    // Test 2: timeout, done in IDLE ignored, next Drdy (with Krdy) clears ERR.
    b0 = bsy_cnt; v0 = dvld_cnt;
    din = mk_din(5'h07, 8'h11, 128'hdeadbeef_00000000_cafef00d_12345678, 1'b1, 1'b0); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    tick(20);
    chk("t2.bsy_cycles", 256'(bsy_cnt - b0), 256'(16));
    chk("t2.ERR", 256'(bus0.ERR), 256'(2'b01));
    chk("t2.Dout_kept", 256'(bus0.Dout), 256'(AES_CT));
    done = 1'b1; ct = 128'h1;
    tick(2);
    done = 1'b0;
    chk("t2.no_dvld", 256'(dvld_cnt - v0), 256'(0));
    kin = 128'hffeeddccbbaa99887766554433221100; krdy = 1'b1;
    din = mk_din(5'h1F, 8'h40, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1'b0); drdy = 1'b1;
    tick(1);
    krdy = 1'b0; drdy = 1'b0;
    chk("t2.ERR_clr", 256'(bus0.ERR), 256'(0));
    chk("t2.new_key", 256'(bus0.core_key), 256'(128'hffeeddccbbaa99887766554433221100));
    chk("t2.Kvld", 256'(bus0.Kvld), 256'(1));
    tick(2);
    done = 1'b1; ct = 128'h0123456789abcdef0123456789abcdef;
    tick(1);
    done = 1'b0;

    // Test 3: overrun Drdy and ignored Krdy mid-RUN.
    din = mk_din(5'h02, 8'h20, 128'haaaa5555aaaa5555aaaa5555aaaa5555, 1'b1, 1'b0); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    tick(2);
    din = mk_din(5'h03, 8'h77, 128'h77777777777777777777777777777777, 1'b1, 1'b0); drdy = 1'b1;
    kin = 128'h5; krdy = 1'b1;
    tick(1);
    drdy = 1'b0; krdy = 1'b0;
    chk("t3.pt_kept", 256'(bus0.core_pt), 256'(128'haaaa5555aaaa5555aaaa5555aaaa5555));
    chk("t3.Kvld", 256'(bus0.Kvld), 256'(0));
    chk("t3.key_kept", 256'(bus0.core_key), 256'(128'hffeeddccbbaa99887766554433221100));
    tick(1);
    done = 1'b1; ct = 128'h33;
    tick(1);
    done = 1'b0;
    chk("t3.ERR", 256'(bus0.ERR), 256'(2'b10));
    chk("t3.Dvld", 256'(bus0.Dvld), 256'(1));

    // Test 4: EN low with done held; Dvld follows EN return, then holds while EN low.
    din = mk_din(5'h0A, 8'h90, 128'h44, 1'b1, 1'b0); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    tick(2);
    en = 1'b0; done = 1'b1; ct = 128'hbeef;
    v0 = dvld_cnt;
    tick(5);
    chk("t4.BSY_frozen", 256'(bus0.BSY), 256'(1));
    chk("t4.no_dvld", 256'(dvld_cnt - v0), 256'(0));
    en = 1'b1;
    tick(1);
    done = 1'b0;
    chk("t4.Dvld", 256'(bus0.Dvld), 256'(1));
    chk("t4.Dout", 256'(bus0.Dout), 256'(128'hbeef));
    en = 1'b0;
    tick(2);
    chk("t4.Dvld_hold", 256'(bus0.Dvld), 256'(1));
    en = 1'b1;
    tick(1);
    chk("t4.Dvld_drop", 256'(bus0.Dvld), 256'(0));

    // Test 5: zero LFSR seed forced to 1; first shifted word is 0xB6.
    din = mk_din(5'h05, 8'h3C, 128'h55, 1'b1, 1'b1); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    tick(1);
    chk("t5.first_word", 256'(bus1.core_rand[D-1:0]), 256'(8'hB6));
    tick(5);
    done = 1'b1; ct = 128'h66;
    tick(1);
    done = 1'b0;
    tick(1);

    // Test 6: async reset three cycles into RUN, then a clean run.
    din = mk_din(5'h01, 8'h01, 128'h99, 1'b1, 1'b0); drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    tick(1);
    drdy = 1'b1;
    tick(1);
    drdy = 1'b0;
    chk("t6.ERR_pre", 256'(bus0.ERR), 256'(2'b10));
    #1 rst = 1'b1;
    #1;
    chk("t6.BSY", 256'(bus0.BSY), 256'(0));
    chk("t6.go", 256'(bus1.core_go), 256'(0));
    chk("t6.Dout", 256'(bus0.Dout), 256'(0));
    chk("t6.ERR", 256'(bus0.ERR), 256'(0));
    tick(1);
    rst = 1'b0;
    b0 = bsy_cnt; v0 = dvld_cnt;
    kin = AES_KEY; krdy = 1'b1;
    din = mk_din(5'h13, 8'hA5, AES_PT, 1'b0, 1'b0); drdy = 1'b1;
    tick(1);
    krdy = 1'b0; drdy = 1'b0;
    tick(10);
    done = 1'b1; ct = AES_CT;
    tick(1);
    done = 1'b0;
    chk("t6.Dout_run", 256'(bus0.Dout), 256'(AES_CT));
    tick(2);
    chk("t6.bsy_cycles", 256'(bsy_cnt - b0), 256'(11));
    chk("t6.dvld_pulses", 256'(dvld_cnt - v0), 256'(1));

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clm_framework_gen.md
Name: clm_framework_gen

Overview:
- Parametrised host-side framework for masked AES cores.
- Accepts key, plaintext, mask selector and randomness from a wide host bus.
- Drives a generic start/done core handshake and returns the ciphertext with a one-cycle valid pulse.
- Adds over the previous framework: independent key loading, real BSY, timeout/overrun error flags, and an optional internal LFSR randomness-refresh mode.

Parameters:
- D, 8: share width; bits per random word (1..16).
- NR, 23: number of random words passed to the core.
- P_W, 5: width of the mask-selector field.
- DIN_W, 512: host data bus width; must satisfy 16*(NR+1)+128 <= DIN_W.
- RAND_MODE, 0: 0 = static randomness from Din; 1 = LFSR refresh every RUN cycle.
- TIMEOUT, 1024: maximum RUN cycles before abort (>= 2).

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- EN  in  1  global enable; when low, all registers hold.
- Kin  in  128  key.
- Krdy  in  1  key-load strobe.
- Din  in  DIN_W  packed data bus.
- Drdy  in  1  data-load/start strobe.
- Dout  out  128  ciphertext.
- Kvld  out  1  key accepted (registered).
- Dvld  out  1  one-cycle result-valid pulse.
- BSY  out  1  high while RUN.
- ERR  out  2  sticky flags: [0] timeout, [1] overrun.
- core_go  out  1  level start to the core.
- core_pt  out  128  plaintext to the core.
- core_key  out  128  key to the core.
- core_rand  out  NR*D  random words; word 0 in the MS bits.
- core_p  out  P_W  mask selector.
- core_done  in  1  core result ready.
- core_ct  in  128  core ciphertext.

Behaviour:
- Reset: all outputs and registers are 0, state IDLE, LFSR = 32'h1.
- EN low: all state, counters and outputs freeze; Dvld holds its value.
- Din layout: p = Din[DIN_W-1 -: P_W]; random word i = Din[DIN_W-17-16*i -: D]; plaintext = Din[127:0].
- FSM states: IDLE, RUN.
- IDLE, EN & Drdy: latch p, randomness and plaintext; clear ERR; go to RUN. core_go and BSY rise the next cycle.
- IDLE, EN & Krdy: latch Kin into core_key.
- Kvld <= Krdy & (state==IDLE) on every EN cycle.
- Krdy and Drdy together in IDLE: both are loaded, and the run uses the new key.
- RUN, core_done sampled high: Dout <= core_ct and Dvld <= 1 for exactly one cycle; return to IDLE. Latency is one edge from done to Dvld.
- RUN timeout: the cycle counter resets on entry to RUN. When it reaches TIMEOUT-1 without core_done: ERR[0] <= 1, return to IDLE, Dvld stays 0, Dout unchanged.
- core_done and the timeout in the same cycle: done wins; no error.
- Drdy in RUN: ignored (no data reload), ERR[1] <= 1.
- Krdy in RUN: ignored, and Kvld stays 0.
- ERR is cleared only by the next accepted Drdy.
- core_done while IDLE: ignored.
- Dvld in any other cycle: 0.
- BSY = (state==RUN), driven from the registered state. core_go = BSY.
- RAND_MODE=1, on Drdy accept: LFSR seed <= Din[DIN_W-17 -: 32]; an all-zero seed is replaced by 32'h1.
- RAND_MODE=1, each RUN cycle: the LFSR (x^32+x^22+x^2+x+1, Fibonacci) advances D steps (unrolled), and core_rand <= {core_rand[NR*D-D-1:0], lfsr_next[D-1:0]}.
- RAND_MODE=0: core_rand is static during RUN.
- Async rst during RUN: immediate return to IDLE; core_go drops asynchronously; no Dvld.

Decomposition:
- Package clm_fw_pkg holds:
  - the state enum;
  - SLOT_W=16;
  - the LFSR taps constant;
  - function slot_hi(i) returning the top bit of random slot i.
- Sub-module clm_fw_lfsr (params D; seed load, step enable, D-bit output).

Test Plan:
- Load: Krdy with Kin=000102…0F, then Drdy with pt=00112233…FF and D=8 random words 0xA5. Core model returns done 10 cycles later with ct=69C4E0D8…C55A → Dvld pulses once, Dout=69C4E0D8…C55A, BSY high for exactly 11 cycles, Kvld pulsed once.
- Timeout, TIMEOUT=16, core never asserts done → BSY falls after 16 cycles, ERR=2'b01, Dvld never pulses; next Drdy clears ERR to 0.
- Overrun: Drdy pulsed mid-RUN with a different pt → core_pt unchanged, ERR=2'b10 after run completes normally, Dvld=1 once.
- EN low for 5 cycles mid-RUN, with done asserted then → no state change; Dvld appears one cycle after EN returns with done still high.
- RAND_MODE=1, seed 0 → LFSR forced to 1; core_rand[D-1:0] matches the reference LFSR model every RUN cycle.
- rst asserted 3 cycles into RUN → BSY/core_go 0 immediately, Dout=0, ERR=0; a fresh run then completes normally.
